// File: rtl/st_gen_pkg.sv
// Shared types and helpers for the Avalon-ST packet source generator.
// Optional LFSR payload is selected with `ST_GEN_LFSR_EN (see st_gen_pattern).
package st_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int          SYMBOLS   = 16;
  localparam int          EMPTY_W   = 4;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] len2beats(input logic [31:0] len_bytes);
    return (len_bytes + 32'(SYMBOLS - 1)) / 32'(SYMBOLS);
  endfunction

  // Right-shifting Galois step: feedback bit is the outgoing LSB.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/st_gen_pattern.sv
// Payload word source: loads on start, advances one beat's worth of words per accepted beat.
// Default is an incrementing counter; `ST_GEN_LFSR_EN selects a 32-bit Galois LFSR instead.
module st_gen_pattern
  import st_gen_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [31:0]       seed_i,
  input  logic              advance_i,
  output logic [DATA_W-1:0] lanes_o
);

  localparam int LANES = DATA_W / 32;

  logic [31:0] word_q, word_d;

`ifdef ST_GEN_LFSR_EN
  logic [31:0] walk;

  // Lane i is the LFSR state i steps ahead; the state after the last lane is the next beat's start.
  always_comb begin
    lanes_o = '0;
    walk    = word_q;
    for (int i = 0; i < LANES; i++) begin
      lanes_o[i*32 +: 32] = walk;
      walk                = lfsr_step(walk);
    end
    word_d = word_q;
    if (load_i) begin
      word_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
    end else if (advance_i) begin
      word_d = walk;
    end
  end
`else
  always_comb begin
    lanes_o = '0;
    for (int i = 0; i < LANES; i++) begin
      lanes_o[i*32 +: 32] = word_q + 32'(i);
    end
    word_d = word_q;
    if (load_i) begin
      word_d = seed_i;
    end else if (advance_i) begin
      word_d = word_q + 32'(LANES);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 32'h0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/st_pkt_source_gen.sv
// Avalon-ST packet generator: runs of fixed-length packets with SOP/EOP/empty, ready latency 0.
// Define `ST_GEN_LFSR_EN to switch the payload from a word counter to a Galois LFSR.
module st_pkt_source_gen
  import st_gen_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int IPG_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   cfg_len_bytes,
  input  logic [CNT_W-1:0]   cfg_num_pkts,
  input  logic [31:0]        cfg_seed,
  output logic [DATA_W-1:0]  src_data,
  output logic               src_valid,
  input  logic               src_ready,
  output logic               src_sop,
  output logic               src_eop,
  output logic [EMPTY_W-1:0] src_empty,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   pkts_sent
);

  localparam logic [15:0] GAP_LAST = 16'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   beat_idx_q, beat_idx_d;
  logic [LEN_W-1:0]   last_beat_q, last_beat_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   pkts_q, pkts_d;
  logic [15:0]        gap_q, gap_d;
  logic               abort_q, abort_d;
  logic               cfg_err_q, cfg_err_d;

  logic               accept;
  logic               is_eop;
  logic               abort_eff;
  logic               load;
  logic [DATA_W-1:0]  lanes;

  assign accept    = (state_q == SEND) && src_ready;
  assign is_eop    = (beat_idx_q == last_beat_q);
  assign abort_eff = abort_q || abort;

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    last_beat_d = last_beat_q;
    empty_d     = empty_q;
    num_d       = num_q;
    pkts_d      = pkts_q;
    gap_d       = gap_q;
    abort_d     = abort_q;
    cfg_err_d   = cfg_err_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (cfg_len_bytes != '0 && cfg_num_pkts != '0) begin
            cfg_err_d   = 1'b0;
            num_d       = cfg_num_pkts;
            last_beat_d = LEN_W'(len2beats(32'(cfg_len_bytes)) - 32'd1);
            // Unused bytes on the last beat: (-len) mod SYMBOLS.
            empty_d     = EMPTY_W'(0) - cfg_len_bytes[EMPTY_W-1:0];
            beat_idx_d  = '0;
            pkts_d      = '0;
            load        = 1'b1;
            state_d     = SEND;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (accept) begin
          if (is_eop) begin
            pkts_d     = pkts_q + CNT_W'(1);
            beat_idx_d = '0;
            gap_d      = '0;
            if ((pkts_q + CNT_W'(1) == num_q) || abort_eff) begin
              state_d = DONE;
            end else if (IPG_CYCLES == 0) begin
              state_d = SEND;
            end else begin
              state_d = GAP;
            end
          end else begin
            beat_idx_d = beat_idx_q + LEN_W'(1);
          end
        end
      end
      GAP: begin
        if (abort_eff) begin
          abort_d = 1'b1;
          state_d = DONE;
        end else if (gap_q == GAP_LAST) begin
          state_d = SEND;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      last_beat_q <= '0;
      empty_q     <= '0;
      num_q       <= '0;
      pkts_q      <= '0;
      gap_q       <= '0;
      abort_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      last_beat_q <= last_beat_d;
      empty_q     <= empty_d;
      num_q       <= num_d;
      pkts_q      <= pkts_d;
      gap_q       <= gap_d;
      abort_q     <= abort_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  st_gen_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .seed_i    (cfg_seed),
    .advance_i (accept),
    .lanes_o   (lanes)
  );

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  assign src_valid = (state_q == SEND);
  assign src_sop   = src_valid && (beat_idx_q == '0);
  assign src_eop   = src_valid && is_eop;
  assign src_empty = src_eop ? empty_q : '0;
  assign src_data  = src_valid ? lanes : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;
  assign pkts_sent = pkts_q;

endmodule

// File: tb/tb_st_pkt_source_gen.sv
// Scoreboard bench for st_pkt_source_gen: expected beats are queued at stimulus time and
// popped by an independent monitor on every accepted beat.
module tb_st_pkt_source_gen;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [15:0]  cfgLen = 16'd0;
   logic [15:0]  cfgNum = 16'd0;
   logic [31:0]  cfgSeed = 32'd0;
   logic         srcReady = 1'b1;
   logic [127:0] srcData;
   logic         srcValid, srcSop, srcEop, busy, done, cfgErr;
   logic [3:0]   srcEmpty;
   logic [15:0]  pktsSent;

   typedef struct {
      logic [127:0] data;
      logic         sop;
      logic         eop;
      logic [3:0]   empty;
   } beat_t;

   beat_t       expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          readyMode = 0;
   int          sopCount = 0;
   int          eopCount = 0;
   logic [31:0] modelWord;

   st_pkt_source_gen dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .cfg_len_bytes (cfgLen),
      .cfg_num_pkts  (cfgNum),
      .cfg_seed      (cfgSeed),
      .src_data      (srcData),
      .src_valid     (srcValid),
      .src_ready     (srcReady),
      .src_sop       (srcSop),
      .src_eop       (srcEop),
      .src_empty     (srcEmpty),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfgErr),
      .pkts_sent     (pktsSent)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference payload sequence: next 32-bit word after w
   function automatic logic [31:0] modelNext(input logic [31:0] w);
`ifdef ST_GEN_LFSR_EN
      return w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
`else
      return w + 32'd1;
`endif
   endfunction

   function automatic logic [31:0] modelSeed(input logic [31:0] s);
`ifdef ST_GEN_LFSR_EN
      return (s == 32'd0) ? 32'd1 : s;
`else
      return s;
`endif
   endfunction

   // Queue the expected beats of npk packets of len bytes, continuing from modelWord
   task automatic pushPackets(input int len, input int npk);
      int    beats;
      beat_t e;
      beats = (len + 15) / 16;
      for (int p = 0; p < npk; p++) begin
         for (int b = 0; b < beats; b++) begin
            for (int l = 0; l < 4; l++) begin
               e.data[l*32 +: 32] = modelWord;
               modelWord = modelNext(modelWord);
            end
            e.sop   = (b == 0);
            e.eop   = (b == beats - 1);
            e.empty = e.eop ? 4'(beats * 16 - len) : 4'd0;
            expQ.push_back(e);
         end
      end
   endtask

   // One-cycle start pulse with the given configuration
   task automatic applyStimulus(input logic [15:0] len, input logic [15:0] num, input logic [31:0] seed);
      @(posedge clk);
      #1;
      cfgLen  = len;
      cfgNum  = num;
      cfgSeed = seed;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for the done pulse, then check the end-of-run state
   task automatic finishRun(input int expPkts);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("done_seen", 128'(ok), 128'd1);
      if (ok) begin
         checkOutput("busy_at_done", 128'(busy), 128'd1);
         checkOutput("pkts_sent", 128'(pktsSent), 128'(expPkts));
         checkOutput("queue_drained", 128'(expQ.size()), 128'd0);
         @(negedge clk);
         checkOutput("done_one_cycle", 128'(done), 128'd0);
         checkOutput("busy_after_done", 128'(busy), 128'd0);
      end else begin
         expQ.delete();
         @(posedge clk);
         #1 reset = 1'b1;
         @(posedge clk);
         #1 reset = 1'b0;
      end
   endtask

   // Ready driver: 0 = always ready, 1 = random 50%, 2 = never ready
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       srcReady = 1'b1;
            1:       srcReady = 1'($urandom_range(0, 1));
            default: srcReady = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on accepted beats, checks stall stability and inter-packet gap
   initial begin
      beat_t e;
      beat_t prev;
      bit    prevStall;
      int    gapCount;
      int    pktsInRun;
      prevStall = 1'b0;
      gapCount  = 0;
      pktsInRun = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prevStall = 1'b0;
            gapCount  = 0;
            pktsInRun = 0;
         end else begin
            if (prevStall) begin
               checkOutput("stall_valid_held", 128'(srcValid), 128'd1);
               checkOutput("stall_data_held", srcData, prev.data);
               checkOutput("stall_flags_held", 128'({srcSop, srcEop, srcEmpty}), 128'({prev.sop, prev.eop, prev.empty}));
            end
            if (!busy) begin
               gapCount  = 0;
               pktsInRun = 0;
            end else if (!srcValid) begin
               gapCount++;
            end
            if (srcValid && srcReady) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_beat: got data %0h sop %0b eop %0b, required no beat", srcData, srcSop, srcEop);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("beat_data", srcData, e.data);
                  checkOutput("beat_sop", 128'(srcSop), 128'(e.sop));
                  checkOutput("beat_eop", 128'(srcEop), 128'(e.eop));
                  checkOutput("beat_empty", 128'(srcEmpty), 128'(e.empty));
               end
               if (srcSop) begin
                  if (pktsInRun > 0) checkOutput("ipg_cycles", 128'(gapCount), 128'd4);
                  gapCount = 0;
                  sopCount++;
               end
               if (srcEop) begin
                  pktsInRun++;
                  eopCount++;
               end
            end
            prevStall  = srcValid && !srcReady;
            prev.data  = srcData;
            prev.sop   = srcSop;
            prev.eop   = srcEop;
            prev.empty = srcEmpty;
         end
      end
   end

   // Watchdog so a stuck design still terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      bit sawValid;
      bit found;
      int base;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_flags", 128'({srcValid, srcSop, srcEop, busy, done, cfgErr}), 128'd0);
      checkOutput("reset_data", srcData, 128'd0);
      checkOutput("reset_pkts_empty", 128'({pktsSent, srcEmpty}), 128'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Bad configurations: len 0, then num 0
      applyStimulus(16'd0, 16'd3, 32'd0);
      sawValid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (srcValid || done || busy) sawValid = 1'b1;
      end
      checkOutput("cfg_err_len0", 128'(cfgErr), 128'd1);
      checkOutput("no_activity_len0", 128'(sawValid), 128'd0);
      applyStimulus(16'd16, 16'd0, 32'd0);
      @(negedge clk);
      checkOutput("cfg_err_num0", 128'({cfgErr, busy}), 128'b10);

      // len 64, 2 packets, seed 0: lanes 0..31, 4-cycle gap
      modelWord = modelSeed(32'd0);
      pushPackets(64, 2);
      applyStimulus(16'd64, 16'd2, 32'd0);
      @(negedge clk);
      checkOutput("first_valid_latency", 128'({srcValid, busy}), 128'b11);
      checkOutput("cfg_err_cleared", 128'(cfgErr), 128'd0);
      finishRun(2);

      // len 20: two beats, empty 12 on EOP
      modelWord = modelSeed(32'h0000_0100);
      pushPackets(20, 1);
      applyStimulus(16'd20, 16'd1, 32'h0000_0100);
      finishRun(1);

      // Wrap of the word counter across beats
      modelWord = modelSeed(32'hFFFF_FFFE);
      pushPackets(32, 1);
      applyStimulus(16'd32, 16'd1, 32'hFFFF_FFFE);
      finishRun(1);

      // Random backpressure, len 100 x 8, with an ignored start mid-run
      readyMode = 1;
      modelWord = modelSeed(32'h1234_0000);
      pushPackets(100, 8);
      applyStimulus(16'd100, 16'd8, 32'h1234_0000);
      repeat (20) @(posedge clk);
      #1;
      cfgLen = 16'd0;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      finishRun(8);
      checkOutput("busy_start_no_cfg_err", 128'(cfgErr), 128'd0);
      readyMode = 0;

      // Abort during packet 3 of 10
      modelWord = modelSeed(32'h0000_5000);
      pushPackets(48, 3);
      base = sopCount;
      applyStimulus(16'd48, 16'd10, 32'h0000_5000);
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (sopCount >= base + 3) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("abort_pkt3_reached", 128'(found), 128'd1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      finishRun(3);

      // Abort during the inter-packet gap: no further SOP
      modelWord = modelSeed(32'h0000_7000);
      pushPackets(16, 1);
      base = eopCount;
      applyStimulus(16'd16, 16'd5, 32'h0000_7000);
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (eopCount >= base + 1) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("abort_gap_reached", 128'(found), 128'd1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      finishRun(1);

      // Async reset while a beat is stalled
      readyMode = 2;
      applyStimulus(16'd32, 16'd1, 32'h0000_9000);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (srcValid) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("stalled_before_reset", 128'({found, srcReady}), 128'b10);
      #2 reset = 1'b1;
      #1;
      checkOutput("reset_async_outputs", 128'({srcValid, srcSop, srcEop, busy}), 128'd0);
      readyMode = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("pkts_after_reset", 128'(pktsSent), 128'd0);

      // Single-beat packet after recovery: sop and eop together, empty 11
      modelWord = modelSeed(32'h0000_00A0);
      pushPackets(5, 1);
      applyStimulus(16'd5, 16'd1, 32'h0000_00A0);
      finishRun(1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
